// File: rtl/ex_mem_stage.sv
// Execute stage of the P5 MIPS pipeline: immediate build, ALU, write-back decode
// and the EX/MEM pipeline register with flush/stall handling.
module ex_mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ins_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [2:0]  alu_op,
  input  logic        alu_type,
  output logic [31:0] ins_m,
  output logic [31:0] pc_m,
  output logic [31:0] alu_out_m,
  output logic [31:0] rt_m,
  output logic [4:0]  wr_addr_m,
  output logic        reg_we_m
);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;

  logic [15:0] imm;
  logic [31:0] b_operand;
  logic [31:0] alu_result;
  logic [4:0]  wr_addr;
  logic        reg_we;

  logic [31:0] ins_d, pc_d, alu_out_d, rt_d;
  logic [4:0]  wr_addr_d;
  logic        reg_we_d;
  logic [31:0] ins_q, pc_q, alu_out_q, rt_q;
  logic [4:0]  wr_addr_q;
  logic        reg_we_q;

  assign imm = ins_e[15:0];

  // ori is the only immediate consumer that wants zero extension
  always_comb begin
    b_operand = rt_val;
    if (alu_type) begin
      if (alu_op == 3'd2) b_operand = {16'h0000, imm};
      else                b_operand = {{16{imm[15]}}, imm};
    end
  end

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      3'd0:    alu_result = rs_val + b_operand;
      3'd1:    alu_result = rs_val - b_operand;
      3'd2:    alu_result = rs_val | b_operand;
      3'd3:    alu_result = {imm, 16'h0000};
      default: alu_result = 32'h0;
    endcase
  end

  always_comb begin
    wr_addr = 5'd0;
    if (ins_e[31:26] == OPC_RTYPE &&
        (ins_e[5:0] == FN_ADDU || ins_e[5:0] == FN_SUBU)) begin
      wr_addr = ins_e[15:11];
    end else if (ins_e[31:26] == OPC_ORI || ins_e[31:26] == OPC_LUI ||
                 ins_e[31:26] == OPC_LW) begin
      wr_addr = ins_e[20:16];
    end
    // writes to $0 are discarded, so they never raise the enable
    reg_we = (wr_addr != 5'd0);
  end

  always_comb begin
    ins_d     = ins_q;
    pc_d      = pc_q;
    alu_out_d = alu_out_q;
    rt_d      = rt_q;
    wr_addr_d = wr_addr_q;
    reg_we_d  = reg_we_q;
    if (flush) begin
      ins_d     = 32'h0;
      pc_d      = RESET_PC;
      alu_out_d = 32'h0;
      rt_d      = 32'h0;
      wr_addr_d = 5'd0;
      reg_we_d  = 1'b0;
    end else if (!stall) begin
      ins_d     = ins_e;
      pc_d      = pc_e;
      alu_out_d = alu_result;
      rt_d      = rt_val;
      wr_addr_d = wr_addr;
      reg_we_d  = reg_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_q     <= 32'h0;
      pc_q      <= RESET_PC;
      alu_out_q <= 32'h0;
      rt_q      <= 32'h0;
      wr_addr_q <= 5'd0;
      reg_we_q  <= 1'b0;
    end else begin
      ins_q     <= ins_d;
      pc_q      <= pc_d;
      alu_out_q <= alu_out_d;
      rt_q      <= rt_d;
      wr_addr_q <= wr_addr_d;
      reg_we_q  <= reg_we_d;
    end
  end

  assign ins_m     = ins_q;
  assign pc_m      = pc_q;
  assign alu_out_m = alu_out_q;
  assign rt_m      = rt_q;
  assign wr_addr_m = wr_addr_q;
  assign reg_we_m  = reg_we_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each driven cycle pushes the expected
// EX/MEM contents, which are popped and compared one cycle later.
module tb_ex_mem_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ins_e = 32'h0, pc_e = 32'h0, rs_val = 32'h0, rt_val = 32'h0;
  logic [2:0]  alu_op = 3'd0;
  logic        alu_type = 1'b0;
  logic [31:0] ins_m, pc_m, alu_out_m, rt_m;
  logic [4:0]  wr_addr_m;
  logic        reg_we_m;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wa;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_mem_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ins_e(ins_e), .pc_e(pc_e), .rs_val(rs_val), .rt_val(rt_val),
    .alu_op(alu_op), .alu_type(alu_type),
    .ins_m(ins_m), .pc_m(pc_m), .alu_out_m(alu_out_m), .rt_m(rt_m),
    .wr_addr_m(wr_addr_m), .reg_we_m(reg_we_m)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.ins = 32'h0; e.pc = RST_PC; e.alu = 32'h0; e.rt = 32'h0; e.wa = 5'd0; e.we = 1'b0;
    return e;
  endfunction

  // Reference model of what one capture should hold
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] rt,
                                 input logic [2:0] op, input logic ty);
    exp_t e;
    logic [31:0] sx, zx, b;
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    b  = ty ? ((op == 3'd2) ? zx : sx) : rt;
    e.ins = ins; e.pc = pc; e.rt = rt;
    if (op == 3'd0)      e.alu = a + b;
    else if (op == 3'd1) e.alu = a - b;
    else if (op == 3'd2) e.alu = a | b;
    else if (op == 3'd3) e.alu = ins[15:0] << 16;
    else                 e.alu = 32'h0;
    case (ins[31:26])
      6'h00:   e.wa = (ins[5:0] == 6'h21 || ins[5:0] == 6'h23) ? ins[15:11] : 5'd0;
      6'h0D, 6'h0F, 6'h23: e.wa = ins[20:16];
      default: e.wa = 5'd0;
    endcase
    e.we = (e.wa != 5'd0);
    return e;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check_val({tag, ".ins"}, ins_m, e.ins);
    check_val({tag, ".pc"}, pc_m, e.pc);
    check_val({tag, ".alu"}, alu_out_m, e.alu);
    check_val({tag, ".rt"}, rt_m, e.rt);
    check_val({tag, ".wa"}, {27'h0, wr_addr_m}, {27'h0, e.wa});
    check_val({tag, ".we"}, {31'h0, reg_we_m}, {31'h0, e.we});
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] rt, input logic [2:0] op,
                      input logic ty, input logic st, input logic fl);
    exp_t e;
    ins_e = ins; pc_e = pc; rs_val = a; rt_val = rt;
    alu_op = op; alu_type = ty; stall = st; flush = fl;
    if (fl)      e = bubble();
    else if (st) e = last;
    else         e = model(ins, pc, a, rt, op, ty);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".empty"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      compare_outputs(tag, e);
      last = e;
    end
    $display("txn %s ins=%h pc=%h alu=%h rt=%h wa=%0d we=%0b",
             tag, ins_m, pc_m, alu_out_m, rt_m, wr_addr_m, reg_we_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_ins;
    logic [2:0]  r_op;
    logic        r_ty;
    repeat (2) @(posedge clk);
    #1;
    compare_outputs("reset", bubble());
    last = bubble();
    reset = 1'b0;

    step("nop",  32'h0000_0000, RST_PC, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("addu", 32'h0022_1821, 32'h3004, 32'hFFFF_FFFF, 32'h2, 3'd0, 1'b0, 1'b0, 1'b0);
    step("subu", 32'h0022_1823, 32'h3008, 32'h0, 32'h1, 3'd1, 1'b0, 1'b0, 1'b0);
    step("ori",  32'h3405_8000, 32'h300C, 32'h0, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0);
    step("lui",  32'h3C04_1234, 32'h3010, 32'h5555_5555, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0);
    step("lw",   32'h8CE6_FFFC, 32'h3014, 32'h10, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("sw",   32'hACE6_FFFC, 32'h3018, 32'h10, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0, 1'b0);
    step("rd0",  32'h0022_0021, 32'h301C, 32'h7, 32'h8, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      step("stall", $urandom, $urandom, $urandom, $urandom, 3'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step("flush_stall", 32'h0022_1821, 32'h4000, 32'h1, 32'h1, 3'd0, 1'b0, 1'b1, 1'b1);
    step("rsvd", 32'h0022_1821, 32'h4004, 32'h1234, 32'h1, 3'd5, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      r_ins = $urandom;
      r_ins[31:26] = (i % 4 == 0) ? 6'h00 : (i % 4 == 1) ? 6'h0D : (i % 4 == 2) ? 6'h0F : 6'h23;
      if (i % 4 == 0) r_ins[5:0] = (i % 8 == 0) ? 6'h21 : 6'h23;
      r_op = (i % 4 == 0) ? 3'(r_ins[1]) : (i % 4 == 1) ? 3'd2 : (i % 4 == 2) ? 3'd3 : 3'd0;
      r_ty = (i % 4 != 0);
      step("b2b", r_ins, $urandom, $urandom, $urandom, r_op, r_ty, 1'b0, 1'b0);
    end

    // asynchronous reset mid-cycle, with stall held, must clear before the next edge
    step("pre_rst", 32'h3C04_ABCD, 32'h5000, 32'h0, 32'h9, 3'd3, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    compare_outputs("midrst", bubble());
    #1;
    reset = 1'b0;
    stall = 1'b0;
    last = bubble();
    step("post_rst", 32'h0022_1821, 32'h3000, 32'h3, 32'h4, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage of the P5 five-stage MIPS pipeline, directly downstream of the ALU-control decoder.
- Consumes the decoder's alu_op/alu_type together with the ID/EX instruction and register operands.
- Builds the immediate operand, performs the ALU operation, and derives the write-back destination and write enable.
- Captures the result in the EX/MEM pipeline register, with stall and flush handling, for the memory stage.

Parameters:
RESET_PC, 32'h0000_3000, value loaded into pc_m on reset and on flush.

Ports:
clk  input  1  system clock; all registers update on the rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hold the EX/MEM register contents.
flush  input  1  load a bubble (nop) into the EX/MEM register.
ins_e  input  32  instruction in EX.
pc_e  input  32  PC of ins_e.
rs_val  input  32  forwarded rs operand.
rt_val  input  32  forwarded rt operand.
alu_op  input  3  0=add, 1=sub, 2=or, 3=lui, 4-7 reserved.
alu_type  input  1  0=B from rt_val, 1=B from immediate.
ins_m  output  32  registered instruction.
pc_m  output  32  registered PC.
alu_out_m  output  32  registered ALU result (also the memory address for lw/sw).
rt_m  output  32  registered rt_val (store data).
wr_addr_m  output  5  registered write-back register number.
reg_we_m  output  1  registered write-back enable.

Behaviour:
- Reset, asynchronous: ins_m, alu_out_m, rt_m = 0; wr_addr_m = 0; reg_we_m = 0; pc_m = RESET_PC.
  - Applies immediately when asserted, including mid-stall.
  - First capture happens on the first rising edge after deassertion.
- Immediate B operand (combinational), with imm = ins_e[15:0]:
  - alu_type=1, alu_op=0: sign-extend imm (lw/sw).
  - alu_type=1, alu_op=2: zero-extend imm (ori).
  - alu_type=1, alu_op=3: operand unused; result = {imm, 16'h0000}.
  - alu_type=0: B = rt_val.
- ALU (combinational):
  - op0: A+B mod 2^32, wraps, no overflow detect.
  - op1: A-B mod 2^32, wraps.
  - op2: A|B.
  - op3: lui value.
  - op4-7: result 0.
- Destination decode from ins_e:
  - opcode ins_e[31:26]==0 and funct 100001/100011 (addu/subu): wr_addr = ins_e[15:11], we = 1.
  - opcode 001101, 001111, 100011 (ori/lui/lw): wr_addr = ins_e[20:16], we = 1.
  - opcode 101011 (sw), ins_e==0 (nop), any other encoding: wr_addr = 0, we = 0.
  - Any computed wr_addr of 0 forces we = 0.
- EX/MEM register update on each rising edge, priority reset > flush > stall > capture:
  - flush: load the bubble (ins_m=0, alu_out_m=0, rt_m=0, wr_addr_m=0, reg_we_m=0, pc_m=RESET_PC).
  - stall (flush=0): all outputs hold.
  - Otherwise: capture ins_e, pc_e, ALU result, rt_val, wr_addr, we.
  - Latency: one cycle from EX inputs to _m outputs.
- No internal state beyond the EX/MEM register; outputs are never driven combinationally from inputs.
- Simultaneous flush and stall: flush wins, and the bubble is loaded.
- Back-to-back captures with stall=0 and flush=0 produce one new result per cycle.

Test Plan:
- Reset then release, ins_e=0 → all _m outputs 0, pc_m=32'h3000; reset asserted mid-cycle clears the outputs before the next edge.
- addu $3,$1,$2 (ins_e=32'h00221821), rs_val=32'hFFFF_FFFF, rt_val=2, alu_op=0, alu_type=0 → next cycle alu_out_m=1 (wrap), wr_addr_m=3, reg_we_m=1.
- subu with rs_val=0, rt_val=1 → alu_out_m=32'hFFFF_FFFF; ori $5,$0,0x8000 (ins_e=32'h34058000, op2, type1, rs_val=0) → alu_out_m=32'h0000_8000, wr_addr_m=5.
- lui $4,0x1234 (ins_e=32'h3C041234, op3, type1) → alu_out_m=32'h1234_0000, wr_addr_m=4, reg_we_m=1.
- lw $6,-4($7) (ins_e=32'h8CE6FFFC, op0, type1, rs_val=32'h10) → alu_out_m=32'hC, wr_addr_m=6, reg_we_m=1.
- sw $6,-4($7) (ins_e=32'hACE6FFFC), rt_val=32'hDEAD_BEEF → alu_out_m=32'hC, rt_m=32'hDEAD_BEEF, reg_we_m=0.
- Hold with stall=1 for 3 cycles while changing the inputs → outputs unchanged; then flush=1 with stall=1 → bubble loaded, reg_we_m=0, pc_m=32'h3000.
